// File: rtl/sys_bus_pkg.sv
// Shared definitions for the sys_* bus slaves: FSM state encodings, the
// default read value and the address window check.
package sys_bus_pkg;

    typedef logic [1:0] bus_state_t;

    localparam bus_state_t ST_IDLE = 2'd0;
    localparam bus_state_t ST_WAIT = 2'd1;
    localparam bus_state_t ST_RESP = 2'd2;
    localparam bus_state_t ST_DONE = 2'd3;

    localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;

    // off_word is the word offset from the window base; an offset that
    // wrapped below the base lands in the upper bits and so fails the check.
    function automatic logic in_window(input logic [29:0] off_word,
                                       input int unsigned aw);
        return (off_word >> aw) == 30'd0;
    endfunction

endpackage

// File: rtl/sys_bram_4x8.sv
// Single-port RAM built from four byte lanes with per-lane write enables and
// a registered (synchronous) read. Read-first on a same-address write.
module sys_bram_4x8 #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [3:0]            i_we,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [0:(2**ADDR_WIDTH)-1];
        logic [7:0] rd_q;

        always_ff @(posedge i_clk) begin
            if (i_we[g]) begin
                mem[i_addr] <= i_wdata[8*g +: 8];
            end
            rd_q <= mem[i_addr];
        end

        assign o_rdata[8*g +: 8] = rd_q;
    end

endmodule

// File: rtl/sys_bram_slave.sv
// Word-addressed block-RAM slave on the sys valid/ready bus with a fixed
// response latency and a sticky out-of-range error flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for i_valid; request fields latched on acceptance
// WAIT    | latency counter running down
// RESP    | o_ready pulse; read data presented, write committed at exit
// DONE    | one dead cycle, i_valid ignored
module sys_bram_slave
    import sys_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    bus_state_t            state_q;
    bus_state_t            state_d;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  in_range_q;
    logic                  err_q;
    logic [31:0]           rdata_hold_q;

    logic                  accept;
    logic [29:0]           off_word;
    logic                  in_range_in;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_we;
    logic [31:0]           mem_rdata;
    logic [31:0]           resp_data;
    logic                  resp_is_read;
    logic                  byte_lane_unused;

    assign byte_lane_unused = ^i_addr[1:0];

    assign accept      = (state_q == ST_IDLE) && i_valid;
    assign off_word    = i_addr[31:2] - BASE_ADDR[31:2];
    assign in_range_in = in_window(off_word, ADDR_WIDTH);

    // The RAM read is launched at the acceptance edge so LATENCY=1 still
    // has data ready in the RESP cycle; afterwards the latched address is
    // re-read every cycle.
    assign mem_addr = (state_q == ST_IDLE) ? off_word[ADDR_WIDTH-1:0] : addr_q;
    assign mem_we   = (state_q == ST_RESP && in_range_q) ? wstrb_q : 4'b0000;

    assign resp_data    = in_range_q ? mem_rdata : RD_DEFAULT;
    assign resp_is_read = (state_q == ST_RESP) && (wstrb_q == 4'b0000);

    sys_bram_4x8 #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_addr  (mem_addr),
        .i_we    (mem_we),
        .i_wdata (wdata_q),
        .o_rdata (mem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_rdata = rdata_hold_q;
        o_err   = err_q;
        if (state_q == ST_RESP) begin
            o_ready = 1'b1;
            o_err   = err_q | ~in_range_q;
            if (resp_is_read) begin
                o_rdata = resp_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= 4'(LATENCY - 1);
        end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            in_range_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= off_word[ADDR_WIDTH-1:0];
            wdata_q    <= i_wdata;
            wstrb_q    <= i_wstrb;
            in_range_q <= in_range_in;
        end
    end

    // Read data is held so o_rdata stays stable between responses.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_q        <= 1'b0;
            rdata_hold_q <= 32'd0;
        end else begin
            if (state_q == ST_RESP && !in_range_q) begin
                err_q <= 1'b1;
            end
            if (resp_is_read) begin
                rdata_hold_q <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_sys_bram_slave.sv
// Directed bench for sys_bram_slave: a default instance (LATENCY=2, base 0)
// and a LATENCY=1 instance based at 0x8000_0000.
module tb_sys_bram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_a, valid_b;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        ready_a, ready_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sys_bram_slave #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (32'h0000_0000),
        .LATENCY    (2)
    ) dut_a (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_valid (valid_a),
        .o_ready (ready_a),
        .i_addr  (addr),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .o_rdata (rdata_a),
        .o_err   (err_a)
    );

    sys_bram_slave #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (32'h8000_0000),
        .LATENCY    (1)
    ) dut_b (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_valid (valid_b),
        .o_ready (ready_b),
        .i_addr  (addr),
        .i_wdata (wdata),
        .i_wstrb (wstrb),
        .o_rdata (rdata_b),
        .o_err   (err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns o_rdata at the ready
    // cycle and the number of negedges from acceptance to ready (0 = timeout).
    task automatic txn(input bit u, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output int lat);
        addr  = a;
        wdata = d;
        wstrb = s;
        if (u) valid_b = 1'b1;
        else   valid_a = 1'b1;
        @(posedge clk);
        #1;
        addr  = ~a;
        wdata = ~d;
        wstrb = ~s;
        lat = 0;
        rd  = 32'hxxxx_xxxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if ((u ? ready_b : ready_a) === 1'b1) begin
                lat = k;
                rd  = u ? rdata_b : rdata_a;
                break;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(negedge clk);
        check(u ? "b_ready_width" : "a_ready_width", {31'd0, u ? ready_b : ready_a}, 32'd0);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    int          lat;
    int          pos[$];
    int          wide;
    logic        prev;
    logic [31:0] b2b_data;

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        addr    = 32'd0;
        wdata   = 32'd0;
        wstrb   = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_ready_a", {31'd0, ready_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_err_a",   {31'd0, err_a},   32'd0);
        check("rst_ready_b", {31'd0, ready_b}, 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        check("rst_err_b",   {31'd0, err_b},   32'd0);
        rst_n = 1'b1;

        txn(0, 32'h10, 32'hCAFE_F00D, 4'hF, rd, lat);
        check("wr10_lat", 32'(lat), 32'd2);
        check("wr10_rdata_untouched", rd, 32'd0);
        txn(0, 32'h10, 32'h0, 4'h0, rd, lat);
        check("rd10_lat", 32'(lat), 32'd2);
        check("rd10_data", rd, 32'hCAFE_F00D);

        txn(0, 32'h20, 32'h1122_3344, 4'hF, rd, lat);
        txn(0, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, lat);
        check("wr20_strb_lat", 32'(lat), 32'd2);
        txn(0, 32'h20, 32'h0, 4'h0, rd, lat);
        check("rd20_merge", rd, 32'h11BB_33DD);
        txn(0, 32'h40, 32'h0, 4'hF, rd, lat);
        check("wr40_holds_rdata", rd, 32'h11BB_33DD);
        check("hold_after_write", rdata_a, 32'h11BB_33DD);

        txn(0, 32'h30, 32'h55AA_55AA, 4'hF, rd, lat);
        txn(0, 32'h30, 32'h0, 4'h0, rd, lat);
        check("rd30_before", rd, 32'h55AA_55AA);
        addr    = 32'h30;
        wdata   = 32'h1234_5678;
        wstrb   = 4'hF;
        valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_wait_ready", {31'd0, ready_a}, 32'd0);
        check("rst_wait_rdata", rdata_a, 32'd0);
        @(negedge clk);
        check("rst_wait_ready_hold", {31'd0, ready_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 32'h30, 32'h0, 4'h0, rd, lat);
        check("rd30_after_rst_lat", 32'(lat), 32'd2);
        check("rd30_after_rst", rd, 32'h55AA_55AA);

        txn(0, 32'hFFC, 32'h0, 4'h0, rd, lat);
        check("last_word_no_err", {31'd0, err_a}, 32'd0);
        txn(0, 32'h1000, 32'h0, 4'h0, rd, lat);
        check("oor_data", rd, 32'hDEAD_BEEF);
        check("oor_err", {31'd0, err_a}, 32'd1);
        txn(0, 32'h10, 32'h0, 4'h0, rd, lat);
        check("after_oor_data", rd, 32'hCAFE_F00D);
        check("err_sticky", {31'd0, err_a}, 32'd1);

        addr     = 32'h10;
        wdata    = 32'h0;
        wstrb    = 4'h0;
        valid_a  = 1'b1;
        wide     = 0;
        prev     = 1'b0;
        b2b_data = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ready_a === 1'b1) begin
                pos.push_back(c);
                b2b_data = rdata_a;
                if (prev) wide++;
            end
            prev = ready_a;
        end
        valid_a = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_count", 32'(pos.size()), 32'd5);
        check("b2b_first", (pos.size() > 0) ? 32'(pos[0]) : 32'hFFFF_FFFF, 32'd1);
        for (int i = 1; i < pos.size(); i++) begin
            check("b2b_gap", 32'(pos[i] - pos[i-1]), 32'd4);
        end
        check("b2b_wide", 32'(wide), 32'd0);
        check("b2b_data", b2b_data, 32'hCAFE_F00D);

        txn(1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, rd, lat);
        check("b_wr_lat", 32'(lat), 32'd1);
        txn(1, 32'h8000_0010, 32'h0, 4'h0, rd, lat);
        check("b_rd_lat", 32'(lat), 32'd1);
        check("b_rd_data", rd, 32'hCAFE_F00D);
        check("b_no_err", {31'd0, err_b}, 32'd0);
        txn(1, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
        check("b_below_base_data", rd, 32'hDEAD_BEEF);
        check("b_below_base_err", {31'd0, err_b}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
